// File: rtl/aes_block_feeder.sv
// Block-level front end for the AES core: takes a 128-bit key/text pair, loads it MSW first
// as four 32-bit words, then waits for aes_done. Optional WAIT timeout: AES_BLOCK_FEEDER_TIMEOUT_EN.
module aes_block_feeder #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [127:0]     blk_key,
  input  logic [127:0]     blk_text,
  input  logic             aes_done,
  output logic             aes_ld,
  output logic [31:0]      aes_key,
  output logic [31:0]      aes_text,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [127:0]     key_q, key_d, text_q, text_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blk_ready_q, blk_ready_d;
  logic             aes_ld_q, aes_ld_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [31:0]      aes_key_q, aes_key_d, aes_text_q, aes_text_d;
  logic             accept;
  logic             timeout_ev;

`ifdef AES_BLOCK_FEEDER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wcnt_q, wcnt_d;
`endif

  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  assign accept = (state_q == ST_IDLE) && blk_valid && blk_ready_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    key_d      = key_q;
    text_d     = text_q;
    cnt_d      = cnt_q;
    timeout_ev = 1'b0;
`ifdef AES_BLOCK_FEEDER_TIMEOUT_EN
    wcnt_d = (state_q == ST_WAIT) ? wcnt_q + 16'd1 : 16'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          key_d   = blk_key;
          text_d  = blk_text;
          idx_d   = 2'd0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // aes_done is deliberately ignored here: anything seen now is stale
        if (idx_q == 2'd3) state_d = ST_WAIT;
        else               idx_d   = idx_q + 2'd1;
      end
      ST_WAIT: begin
        if (aes_done) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
`ifdef AES_BLOCK_FEEDER_TIMEOUT_EN
        else if (wcnt_q == TO_LAST) begin
          state_d    = ST_IDLE;
          timeout_ev = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state
    blk_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    aes_ld_d    = (state_d == ST_LOAD);
    aes_key_d   = aes_ld_d ? word_sel(key_d, idx_d)  : 32'd0;
    aes_text_d  = aes_ld_d ? word_sel(text_d, idx_d) : 32'd0;
    err_d       = timeout_ev;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      key_q       <= '0;
      text_q      <= '0;
      cnt_q       <= '0;
      blk_ready_q <= 1'b1;
      aes_ld_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      aes_key_q   <= '0;
      aes_text_q  <= '0;
`ifdef AES_BLOCK_FEEDER_TIMEOUT_EN
      wcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      key_q       <= key_d;
      text_q      <= text_d;
      cnt_q       <= cnt_d;
      blk_ready_q <= blk_ready_d;
      aes_ld_q    <= aes_ld_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      aes_key_q   <= aes_key_d;
      aes_text_q  <= aes_text_d;
`ifdef AES_BLOCK_FEEDER_TIMEOUT_EN
      wcnt_q      <= wcnt_d;
`endif
    end
  end

  assign blk_ready = blk_ready_q;
  assign aes_ld    = aes_ld_q;
  assign aes_key   = aes_key_q;
  assign aes_text  = aes_text_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_aes_block_feeder.sv
// Self-checking bench for aes_block_feeder: directed and random blocks against a word-order model.
// Timeout scenarios run only when AES_BLOCK_FEEDER_TIMEOUT_EN is defined.
module tb_aes_block_feeder;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_key, blk_text;
  logic         aes_done;
  logic         aes_ld;
  logic [31:0]  aes_key, aes_text;
  logic         busy, err;
  logic [15:0]  blk_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  aes_block_feeder #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_key(blk_key), .blk_text(blk_text),
    .aes_done(aes_done), .aes_ld(aes_ld),
    .aes_key(aes_key), .aes_text(aes_text),
    .busy(busy), .err(err), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // mode 0: complete after dly WAIT cycles; 1: let it time out; 2: done on the timeout cycle
  task automatic run_block(input logic [127:0] k, input logic [127:0] t, input int dly,
                           input bit spur, input bit hold, input int mode);
    logic [127:0] sk, st;
    blk_key = k; blk_text = t; blk_valid = 1'b1;
    chk("ready_idle", blk_ready, 1);
    @(negedge clk);
    if (!hold) blk_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sk = k >> (32 * (3 - i));
      st = t >> (32 * (3 - i));
      chk("ld_load", aes_ld, 1);
      chk("key_word", aes_key, sk[31:0]);
      chk("text_word", aes_text, st[31:0]);
      chk("busy_load", busy, 1);
      chk("ready_load", blk_ready, 0);
      aes_done = spur && (i == 1);
      @(negedge clk);
    end
    aes_done = 1'b0;
    chk("ld_wait", aes_ld, 0);
    chk("key_wait", aes_key, 0);
    chk("text_wait", aes_text, 0);
    chk("busy_wait", busy, 1);
    if (mode == 0) begin
      repeat (dly) begin
        @(negedge clk);
        chk("busy_hold", busy, 1);
        chk("ld_hold", aes_ld, 0);
      end
      aes_done = 1'b1;
      @(negedge clk);
      aes_done = 1'b0;
      exp_cnt++;
      chk("err_done", err, 0);
    end else begin
      repeat (TO - 1) begin
        chk("err_early", err, 0);
        chk("busy_to", busy, 1);
        @(negedge clk);
      end
      aes_done = (mode == 2);
      @(negedge clk);
      aes_done = 1'b0;
      if (mode == 2) exp_cnt++;
      chk("err_to", err, (mode == 1));
    end
    chk("ready_ret", blk_ready, 1);
    chk("busy_ret", busy, 0);
    chk("ld_ret", aes_ld, 0);
    chk("count", blk_count, 16'(exp_cnt));
  endtask

  initial begin
    logic [127:0] k0, t0;
    rst = 1'b0; blk_valid = 1'b1; aes_done = 1'b0;
    blk_key = 128'h000102030405060708090a0b0c0d0e0f;
    blk_text = 128'h00112233445566778899aabbccddeeff;
    repeat (3) @(negedge clk);
    chk("rst_ready", blk_ready, 1);
    chk("rst_ld", aes_ld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", blk_count, 0);
    chk("rst_err", err, 0);
    chk("rst_key", aes_key, 0);
    rst = 1'b1; blk_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ld", aes_ld, 0);
    chk("post_rst_busy", busy, 0);

    // reset in the middle of LOAD
    k0 = rand128(); t0 = rand128();
    blk_key = k0; blk_text = t0; blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midload_word2", aes_key, k0[63:32]);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_ld", aes_ld, 0);
    chk("midrst_ready", blk_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", blk_count, 16'(exp_cnt));

    // known vector, then spurious done during LOAD
    run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 2, 1'b0, 1'b0, 0);
    run_block(rand128(), rand128(), 3, 1'b1, 1'b0, 0);

    // backpressure: valid held high across three blocks
    for (int b = 0; b < 3; b++) run_block(rand128(), rand128(), b, 1'b0, 1'b1, 0);
    blk_valid = 1'b0;

    for (int r = 0; r < 12; r++) begin
      run_block(rand128(), rand128(), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0);
      blk_valid = 1'b0;
    end

`ifdef AES_BLOCK_FEEDER_TIMEOUT_EN
    run_block(rand128(), rand128(), 0, 1'b0, 1'b0, 1);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    run_block(rand128(), rand128(), 0, 1'b0, 1'b0, 2);
    @(negedge clk);
    chk("err_after_tie", err, 0);
`endif

    @(negedge clk);
    chk("idle_no_capture", busy, 0);
    chk("final_count", blk_count, 16'(exp_cnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
